// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and transmitter-side signals of the shared UART TX arbiter.
// master: the message producers together with the uart_tx instance.
// slave : the arbiter itself.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0]   src_req;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic [NUM_SRC-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;
  logic                 timeout_err;

  modport master (
    output src_req, src_data, src_valid, src_last, tx_busy,
    input  src_ready, grant, tx_data, new_tx_data, timeout_err
  );

  modport slave (
    input  src_req, src_data, src_valid, src_last, tx_busy,
    output src_ready, grant, tx_data, new_tx_data, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one uart_tx among NUM_SRC
// producers. A winning source keeps the transmitter until it sends a byte
// flagged last, drops its request, or sits idle for TIMEOUT_CYCLES.
//
// Optional feature macro: UART_ARB_SRC_TAG_EN
//   When defined, every granted message is prefixed on the wire with the
//   ASCII digit of its source index (8'h30 + index).
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    ISSUE,
    SETTLE
`ifdef UART_ARB_SRC_TAG_EN
    ,
    TAG
`endif
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   last_winner_q;
  logic [7:0]         tx_data_q;
  logic               new_tx_q;
  logic               timeout_q;
  logic               last_flag_q;
  logic [CNT_W-1:0]   cnt_q;

  // Arbitration result
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;

  // Views of the currently granted source
  logic               g_req;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;

  // Decisions taken by the next-state logic
  logic               do_grant;
  logic               do_accept;
  logic               do_release;
  logic               do_timeout;
  logic               cnt_inc;
`ifdef UART_ARB_SRC_TAG_EN
  logic               do_tag;
`endif

  logic [NUM_SRC-1:0] src_ready_c;

  // Round-robin search upward from last_winner+1, wrapping modulo NUM_SRC.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = IDX_W'((32'(last_winner_q) + i) % NUM_SRC);
      if (!sel_valid && bus.src_req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Select the granted source's request, byte and flags.
  always_comb begin
    g_req   = bus.src_req[grant_idx_q];
    g_valid = bus.src_valid[grant_idx_q];
    g_last  = bus.src_last[grant_idx_q];
    g_data  = bus.src_data[{grant_idx_q, 3'b000} +: 8];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and per-cycle decisions.
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_accept  = 1'b0;
    do_release = 1'b0;
    do_timeout = 1'b0;
    cnt_inc    = 1'b0;
`ifdef UART_ARB_SRC_TAG_EN
    do_tag     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          do_grant = 1'b1;
`ifdef UART_ARB_SRC_TAG_EN
          state_d  = TAG;
`else
          state_d  = ACTIVE;
`endif
        end
      end
      ACTIVE: begin
        if (!g_req) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end else if (g_valid && !bus.tx_busy) begin
          do_accept = 1'b1;
          state_d   = ISSUE;
        end else if (!g_valid && !bus.tx_busy) begin
          // The idle-cycle counter only advances while the UART is free.
          if (cnt_q == CNT_LIMIT) begin
            do_timeout = 1'b1;
            do_release = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (last_flag_q) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
`ifdef UART_ARB_SRC_TAG_EN
      TAG: begin
        if (!bus.tx_busy) begin
          do_tag  = 1'b1;
          state_d = ISSUE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Combinational byte-accept strobe, only ever to the granted source.
  always_comb begin
    src_ready_c = '0;
    if (do_accept) src_ready_c[grant_idx_q] = 1'b1;
  end

  // Grant ownership, latched byte, strobes and idle-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= '0;
      grant_idx_q   <= '0;
      last_winner_q <= LAST_IDX;
      tx_data_q     <= '0;
      new_tx_q      <= 1'b0;
      timeout_q     <= 1'b0;
      last_flag_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      // The strobe is registered so it coincides with the ISSUE state.
      new_tx_q  <= (state_d == ISSUE);
      timeout_q <= do_timeout;

      if (do_grant) begin
        grant_q     <= NUM_SRC'(1) << sel_idx;
        grant_idx_q <= sel_idx;
        cnt_q       <= '0;
      end

      if (do_release) begin
        grant_q       <= '0;
        last_winner_q <= grant_idx_q;
      end

      if (do_accept) begin
        tx_data_q   <= g_data;
        last_flag_q <= g_last;
        cnt_q       <= '0;
      end else if (cnt_inc && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end

`ifdef UART_ARB_SRC_TAG_EN
      if (do_tag) begin
        tx_data_q   <= 8'h30 + 8'(grant_idx_q);
        last_flag_q <= 1'b0;
        cnt_q       <= '0;
      end
`endif
    end
  end

  assign bus.src_ready   = src_ready_c;
  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;
  assign bus.timeout_err = timeout_q;

  // Structural invariants.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));
  a_ready_owner: assert property (@(posedge clk) disable iff (rst)
    (src_ready_c & ~grant_q) == '0);
  a_strobe_issue: assert property (@(posedge clk) disable iff (rst)
    new_tx_q |-> (state_q == ISSUE));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a small producer model per source
// feeds queued message bytes, and the wire bytes, grant order and strobes
// are compared against hand-derived expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned NSRC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_SRC(NSRC)) bus ();

  uart_tx_arbiter #(
    .NUM_SRC(NSRC),
    .IDX_W(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Producer model
  logic [7:0]  mem     [NSRC][4];
  int unsigned len     [NSRC];
  int unsigned pos     [NSRC];
  logic        req_en  [NSRC];
  logic        hold    [NSRC];
  logic        busy_v;
  logic [NSRC-1:0] cur_ready;

  // Observation logs
  logic [7:0]  wire_q[$];
  int unsigned wire_src_q[$];
  int unsigned grant_log[$];
  int unsigned te_pulses;
  int unsigned stray_ready;
  int unsigned ready_cnt [NSRC];
  logic [NSRC-1:0] prev_grant;

  function automatic int unsigned onehot_idx(input logic [NSRC-1:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < NSRC; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive();
    logic act;
    for (int i = 0; i < NSRC; i++) begin
      act = req_en[i] && (pos[i] < len[i]);
      bus.src_req[i]   = act;
      bus.src_valid[i] = act && !hold[i];
      bus.src_last[i]  = act && !hold[i] && (pos[i] == len[i] - 1);
      bus.src_data[i*8 +: 8] = act ? mem[i][pos[i]] : 8'h00;
    end
    bus.tx_busy = busy_v;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NSRC; i++) begin
      len[i] = 0; pos[i] = 0; req_en[i] = 1'b0; hold[i] = 1'b0; ready_cnt[i] = 0;
      for (int k = 0; k < 4; k++) mem[i][k] = 8'h00;
    end
    busy_v = 1'b0;
    cur_ready = '0;
    wire_q.delete();
    wire_src_q.delete();
    grant_log.delete();
    te_pulses = 0;
    prev_grant = '0;
  endtask

  task automatic load(input int s, input int n, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2);
    mem[s][0] = b0; mem[s][1] = b1; mem[s][2] = b2;
    len[s] = n; pos[s] = 0; req_en[s] = 1'b1; hold[s] = 1'b0;
  endtask

  // One clock: log registered outputs just after the edge, drive new
  // inputs, then sample the combinational ready mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NSRC; i++) if (cur_ready[i]) pos[i]++;
    if (bus.new_tx_data) begin
      wire_q.push_back(bus.tx_data);
      wire_src_q.push_back(onehot_idx(bus.grant));
    end
    if (bus.timeout_err) te_pulses++;
    if (bus.grant != '0 && bus.grant != prev_grant) grant_log.push_back(onehot_idx(bus.grant));
    prev_grant = bus.grant;
    drive();
    #3;
    cur_ready = bus.src_ready;
    for (int i = 0; i < NSRC; i++) if (cur_ready[i]) ready_cnt[i]++;
    if ((cur_ready & ~bus.grant) != '0) stray_ready++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    step();
    step();
    rst = 1'b0;
    clear_all();
  endtask

  task automatic test_reset();
    stray_ready = 0;
    clear_all();
    drive();
    rst = 1'b1;
    step(); step(); step();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
    checks++; if (bus.new_tx_data !== 1'b0) begin errors++; $display("FAIL reset_new_tx: got %b expected 0", bus.new_tx_data); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_err); end
    checks++; if (cur_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", cur_ready); end
    rst = 1'b0;
    step();
  endtask

`ifndef UART_ARB_SRC_TAG_EN
  task automatic test_single_source();
    clear_all();
    load(1, 2, 8'h68, 8'h69, 8'h00);
    step(); // request visible to the arbiter
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_grant_early: got %b expected 0000", bus.grant); end
    step();
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", bus.grant); end
    checks++; if (cur_ready !== 4'b0010) begin errors++; $display("FAIL single_ready0: got %b expected 0010", cur_ready); end
    step();
    checks++; if (bus.new_tx_data !== 1'b1 || bus.tx_data !== 8'h68) begin errors++; $display("FAIL single_byte0: got %b/%h expected 1/68", bus.new_tx_data, bus.tx_data); end
    step();
    checks++; if (bus.new_tx_data !== 1'b0 || bus.tx_data !== 8'h68) begin errors++; $display("FAIL single_settle: got %b/%h expected 0/68", bus.new_tx_data, bus.tx_data); end
    step();
    checks++; if (cur_ready !== 4'b0010) begin errors++; $display("FAIL single_ready1: got %b expected 0010", cur_ready); end
    step();
    checks++; if (bus.new_tx_data !== 1'b1 || bus.tx_data !== 8'h69) begin errors++; $display("FAIL single_byte1: got %b/%h expected 1/69", bus.new_tx_data, bus.tx_data); end
    step();
    checks++; if (bus.grant !== 4'b0010) begin errors++; $display("FAIL single_hold_settle: got %b expected 0010", bus.grant); end
    step();
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b expected 0000", bus.grant); end
    checks++; if (ready_cnt[1] != 2 || wire_q.size() != 2) begin errors++; $display("FAIL single_counts: got ready=%0d bytes=%0d expected 2/2", ready_cnt[1], wire_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [7:0]  exp_b [12] = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23,
                                8'h04, 8'h05, 8'h06, 8'h24, 8'h25, 8'h26};
    int unsigned exp_s [12] = '{0, 0, 0, 2, 2, 2, 0, 0, 0, 2, 2, 2};
    int unsigned exp_g [4]  = '{0, 2, 0, 2};
    int unsigned n;
    do_reset();
    load(0, 3, 8'h01, 8'h02, 8'h03);
    load(2, 3, 8'h21, 8'h22, 8'h23);
    n = 0;
    while (!(wire_q.size() == 6 && bus.grant == '0) && n < 100) begin step(); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rr_round1_wait: got %0d bytes expected 6 within 100 cycles", wire_q.size()); end
    load(0, 3, 8'h04, 8'h05, 8'h06);
    load(2, 3, 8'h24, 8'h25, 8'h26);
    n = 0;
    while (!(wire_q.size() == 12 && bus.grant == '0) && n < 100) begin step(); n++; end
    checks++; if (wire_q.size() != 12) begin errors++; $display("FAIL rr_byte_count: got %0d expected 12", wire_q.size()); end
    for (int k = 0; k < 12 && k < wire_q.size(); k++) begin
      checks++; if (wire_q[k] !== exp_b[k] || wire_src_q[k] != exp_s[k]) begin errors++; $display("FAIL rr_byte%0d: got %h/src%0d expected %h/src%0d", k, wire_q[k], wire_src_q[k], exp_b[k], exp_s[k]); end
    end
    checks++; if (grant_log.size() != 4) begin errors++; $display("FAIL rr_grant_count: got %0d expected 4", grant_log.size()); end
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      checks++; if (grant_log[k] != exp_g[k]) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, grant_log[k], exp_g[k]); end
    end
  endtask

  task automatic test_busy();
    do_reset();
    busy_v = 1'b1;
    load(3, 1, 8'h5A, 8'h00, 8'h00);
    repeat (20) step();
    checks++; if (ready_cnt[3] != 0) begin errors++; $display("FAIL busy_ready_held: got %0d pulses expected 0", ready_cnt[3]); end
    checks++; if (wire_q.size() != 0) begin errors++; $display("FAIL busy_no_strobe: got %0d bytes expected 0", wire_q.size()); end
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL busy_grant: got %b expected 1000", bus.grant); end
    busy_v = 1'b0;
    step();
    checks++; if (cur_ready !== 4'b1000) begin errors++; $display("FAIL busy_release_ready: got %b expected 1000", cur_ready); end
    step();
    checks++; if (bus.new_tx_data !== 1'b1 || bus.tx_data !== 8'h5A) begin errors++; $display("FAIL busy_issue: got %b/%h expected 1/5a", bus.new_tx_data, bus.tx_data); end
    checks++; if (te_pulses != 0) begin errors++; $display("FAIL busy_no_timeout: got %0d expected 0", te_pulses); end
  endtask

  task automatic test_timeout();
    int unsigned n;
    do_reset();
    load(0, 1, 8'hEE, 8'h00, 8'h00);
    hold[0] = 1'b1;
    load(1, 1, 8'h77, 8'h00, 8'h00);
    step();
    step(); // grant to source 0, first idle cycle
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL to_grant0: got %b expected 0001", bus.grant); end
    repeat (9) step();  // ten idle cycles with the UART free
    busy_v = 1'b1;
    repeat (5) step();  // busy: idle count holds
    busy_v = 1'b0;
    repeat (5) step();  // fifteen idle cycles counted so far
    checks++; if (te_pulses != 0 || bus.grant !== 4'b0001) begin errors++; $display("FAIL to_early: got pulses=%0d grant=%b expected 0/0001", te_pulses, bus.grant); end
    step();             // sixteenth idle cycle revokes the grant
    checks++; if (bus.timeout_err !== 1'b0 || bus.grant !== 4'b0001) begin errors++; $display("FAIL to_last_idle: got %b/%b expected 0/0001", bus.timeout_err, bus.grant); end
    step();
    checks++; if (bus.timeout_err !== 1'b1 || bus.grant !== 4'b0000) begin errors++; $display("FAIL to_pulse: got %b/%b expected 1/0000", bus.timeout_err, bus.grant); end
    req_en[0] = 1'b0;
    step();
    checks++; if (bus.timeout_err !== 1'b0 || bus.grant !== 4'b0010) begin errors++; $display("FAIL to_next_grant: got %b/%b expected 0/0010", bus.timeout_err, bus.grant); end
    n = 0;
    while (!(wire_q.size() == 1 && bus.grant == '0) && n < 50) begin step(); n++; end
    checks++; if (wire_q.size() != 1 || wire_q[0] !== 8'h77) begin errors++; $display("FAIL to_src1_byte: got %0d bytes expected one 77", wire_q.size()); end
    checks++; if (te_pulses != 1) begin errors++; $display("FAIL to_pulse_count: got %0d expected 1", te_pulses); end
  endtask

  task automatic test_reset_mid_message();
    int unsigned n;
    do_reset();
    load(0, 3, 8'h11, 8'h22, 8'h33);
    step();
    step();
    step(); // ISSUE for the first byte
    checks++; if (bus.new_tx_data !== 1'b1 || bus.tx_data !== 8'h11) begin errors++; $display("FAIL rm_issue: got %b/%h expected 1/11", bus.new_tx_data, bus.tx_data); end
    rst = 1'b1;
    req_en[0] = 1'b0;
    step();
    checks++; if (bus.new_tx_data !== 1'b0 || bus.grant !== 4'b0000 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL rm_after_reset: got %b/%b/%h expected 0/0000/00", bus.new_tx_data, bus.grant, bus.tx_data); end
    rst = 1'b0;
    wire_q.delete();
    wire_src_q.delete();
    repeat (4) step();
    checks++; if (wire_q.size() != 0) begin errors++; $display("FAIL rm_no_strobe: got %0d bytes expected 0", wire_q.size()); end
    load(0, 1, 8'hAB, 8'h00, 8'h00);
    n = 0;
    while (!(wire_q.size() == 1 && bus.grant == '0) && n < 50) begin step(); n++; end
    checks++; if (wire_q.size() != 1 || wire_q[0] !== 8'hAB) begin errors++; $display("FAIL rm_fresh: got %0d bytes expected one ab", wire_q.size()); end
  endtask
`else
  task automatic test_tag();
    int unsigned n;
    do_reset();
    load(2, 1, 8'h41, 8'h00, 8'h00);
    n = 0;
    while (!(wire_q.size() == 2 && bus.grant == '0) && n < 50) begin step(); n++; end
    checks++; if (wire_q.size() != 2) begin errors++; $display("FAIL tag_count: got %0d expected 2", wire_q.size()); end
    checks++; if (wire_q.size() > 0 && wire_q[0] !== 8'h32) begin errors++; $display("FAIL tag_prefix: got %h expected 32", wire_q[0]); end
    checks++; if (wire_q.size() > 1 && wire_q[1] !== 8'h41) begin errors++; $display("FAIL tag_body: got %h expected 41", wire_q[1]); end
    checks++; if (ready_cnt[2] != 1) begin errors++; $display("FAIL tag_ready_once: got %0d expected 1", ready_cnt[2]); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef UART_ARB_SRC_TAG_EN
    test_single_source();
    test_round_robin();
    test_busy();
    test_timeout();
    test_reset_mid_message();
`else
    test_tag();
`endif
    checks++; if (stray_ready != 0) begin errors++; $display("FAIL stray_ready: got %0d cycles expected 0", stray_ready); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
